// File: rtl/aes_block_capture_if.sv
// Write-port and block-output bundle for aes_block_capture.
// master = AES write side plus UART ready; slave = the capture block.
interface aes_block_capture_if #(
  parameter int WORD_W  = 1,
  parameter int BLOCK_W = 128,
  parameter int ADDR_W  = 7
);
  logic               a_ce;
  logic               a_we;
  logic [ADDR_W-1:0]  a_addr;
  logic [WORD_W-1:0]  a_d;
  logic               b_ce;
  logic               b_we;
  logic [ADDR_W-1:0]  b_addr;
  logic [WORD_W-1:0]  b_d;
  logic [BLOCK_W-1:0] out_block;
  logic               out_valid;
  logic               out_ready;
  logic               out_partial;

  modport master (
    output a_ce, a_we, a_addr, a_d,
    output b_ce, b_we, b_addr, b_d,
    output out_ready,
    input  out_block, out_valid, out_partial
  );

  modport slave (
    input  a_ce, a_we, a_addr, a_d,
    input  b_ce, b_we, b_addr, b_d,
    input  out_ready,
    output out_block, out_valid, out_partial
  );
endinterface

// File: rtl/aes_block_capture.sv
// Assembles AES cipher-text RAM writes (ports A/B) into one block and hands it to the UART TX path.
// Define AES_CAPTURE_MSB_FIRST_EN to place address 0 in the block MSB instead of the LSB.
module aes_block_capture #(
  parameter int WORD_W  = 1,
  parameter int BLOCK_W = 128,
  parameter int ADDR_W  = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  aes_block_capture_if.slave   bus,
  input  logic                 done_i,
  input  logic                 clear_i,
  output logic                 overrun,
  output logic                 addr_err,
  output logic [7:0]           overrun_cnt
);

  localparam int              DEPTH   = BLOCK_W / WORD_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   mask_q, mask_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               partial_q, partial_d;
  logic               valid_q;

  logic               a_act, b_act;
  logic               a_in, b_in;
  logic               err_now;
  logic [1:0]         drop_cnt;
  logic [7:0]         cnt_base;
  logic [8:0]         cnt_sum;

  function automatic int slot_lo(input int idx);
`ifdef AES_CAPTURE_MSB_FIRST_EN
    return BLOCK_W - (idx + 1) * WORD_W;
`else
    return idx * WORD_W;
`endif
  endfunction

  assign a_act   = bus.a_ce & bus.a_we;
  assign b_act   = bus.b_ce & bus.b_we;
  assign a_in    = ({1'b0, bus.a_addr} < DEPTH_L);
  assign b_in    = ({1'b0, bus.b_addr} < DEPTH_L);
  assign err_now = (a_act & ~a_in) | (b_act & ~b_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Port B is applied after port A so it wins a same-address collision.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    block_d   = block_q;
    partial_d = partial_q;
    drop_cnt  = 2'd0;
    case (state_q)
      COLLECT: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (a_act && bus.a_addr == ADDR_W'(i)) begin
            block_d[slot_lo(i) +: WORD_W] = bus.a_d;
            mask_d[i]                     = 1'b1;
          end
          if (b_act && bus.b_addr == ADDR_W'(i)) begin
            block_d[slot_lo(i) +: WORD_W] = bus.b_d;
            mask_d[i]                     = 1'b1;
          end
        end
        if ((&mask_d) || done_i) begin
          state_d   = HOLD;
          partial_d = ~&mask_d;
        end
      end
      HOLD: begin
        drop_cnt = {1'b0, a_act} + {1'b0, b_act};
        if (bus.out_ready) begin
          state_d = COLLECT;
          mask_d  = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      block_q   <= '0;
      partial_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      block_q   <= block_d;
      partial_q <= partial_d;
      valid_q   <= (state_d == HOLD);
    end
  end

  // A clear in the same cycle as a drop still records that drop.
  assign cnt_base = clear_i ? 8'd0 : overrun_cnt;
  assign cnt_sum  = {1'b0, cnt_base} + {7'd0, drop_cnt};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      addr_err    <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      overrun     <= (overrun & ~clear_i) | (drop_cnt != 2'd0);
      addr_err    <= (addr_err & ~clear_i) | err_now;
      overrun_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

  assign bus.out_block   = block_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_partial = partial_q;

endmodule
